// File: rtl/bch_serial_rx.sv
// Bit-serial receive front end for BCH(15,7,2): assembles a codeword MSB first,
// computes S1/S3 over GF(16) by Horner's rule and holds the result in a one-entry output register.
module bch_serial_rx #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   input  logic                 s_bit,
   input  logic                 s_sof,
   output logic                 s_ready,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [14:0]          m_word,
   output logic [3:0]           m_s1,
   output logic [3:0]           m_s3,
   output logic                 m_err,
   output logic                 frame_abort,
   output logic [ERR_CNT_W-1:0] err_count,
   input  logic                 cnt_clr
);

   typedef enum logic {
      IDLE,
      RECV
   } state_t;

   // GF(16) multiply by alpha, field polynomial x^4+x+1
   function automatic logic [3:0] mul_alpha(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? 4'd3 : 4'd0);
   endfunction

   state_t      state;
   logic [3:0]  bit_cnt;
   logic [13:0] shift;
   logic [3:0]  acc1;
   logic [3:0]  acc3;

   logic        acc;
   logic        start_frame;
   logic        cont_bit;
   logic        last_bit;
   logic [14:0] word_nxt;
   logic [3:0]  acc1_nxt;
   logic [3:0]  acc3_nxt;
   logic        err_nxt;

   // Only the 15th bit position waits on a full output register.
   assign s_ready = (bit_cnt != 4'd14) || !m_valid || m_ready;

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      acc         = s_valid && s_ready;
      start_frame = acc && s_sof;
      cont_bit    = acc && !s_sof && (state == RECV);
      last_bit    = cont_bit && (bit_cnt == 4'd14);
      word_nxt    = {shift, s_bit};
      acc1_nxt    = mul_alpha(acc1) ^ {3'b000, s_bit};
      acc3_nxt    = mul_alpha(mul_alpha(mul_alpha(acc3))) ^ {3'b000, s_bit};
      err_nxt     = (acc1_nxt != 4'd0) || (acc3_nxt != 4'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
         state       <= IDLE;
         bit_cnt     <= 4'd0;
         shift       <= 14'd0;
         acc1        <= 4'd0;
         acc3        <= 4'd0;
         m_valid     <= 1'b0;
         m_word      <= 15'd0;
         m_s1        <= 4'd0;
         m_s3        <= 4'd0;
         m_err       <= 1'b0;
         frame_abort <= 1'b0;
         err_count   <= '0;
      end else begin
         frame_abort <= start_frame && (state == RECV);

         if (start_frame) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
            shift   <= {13'd0, s_bit};
            acc1    <= {3'b000, s_bit};
            acc3    <= {3'b000, s_bit};
         end else if (last_bit) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= 14'd0;
            acc1    <= 4'd0;
            acc3    <= 4'd0;
         end else if (cont_bit) begin
            bit_cnt <= bit_cnt + 4'd1;
            shift   <= word_nxt[13:0];
            acc1    <= acc1_nxt;
            acc3    <= acc3_nxt;
         end

         // A new load wins over a simultaneous downstream accept.
         if (last_bit) begin
            m_valid <= 1'b1;
            m_word  <= word_nxt;
            m_s1    <= acc1_nxt;
            m_s3    <= acc3_nxt;
            m_err   <= err_nxt;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end

         if (cnt_clr) begin
            err_count <= '0;
         end else if (last_bit && err_nxt && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bch_serial_rx.sv
// Directed bench for bch_serial_rx: table of codewords with hand-computed syndromes,
// plus sequences for backpressure, abort, reset mid-frame and counter saturation.
module tb_bch_serial_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_bit;
   logic        s_sof;
   logic        s_ready;
   logic        m_valid;
   logic        m_ready;
   logic [14:0] m_word;
   logic [3:0]  m_s1;
   logic [3:0]  m_s3;
   logic        m_err;
   logic        frame_abort;
   logic [7:0]  err_count;
   logic        cnt_clr;

   always #5 clk = ~clk;

   bch_serial_rx #(.ERR_CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_bit      (s_bit),
      .s_sof      (s_sof),
      .s_ready    (s_ready),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_word     (m_word),
      .m_s1       (m_s1),
      .m_s3       (m_s3),
      .m_err      (m_err),
      .frame_abort(frame_abort),
      .err_count  (err_count),
      .cnt_clr    (cnt_clr)
   );

   typedef struct {
      logic [14:0] word;
      logic [3:0]  s1;
      logic [3:0]  s3;
      logic        err;
   } vec_t;

   vec_t vecs[7];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   abort_seen = 0;
   int   out_seen   = 0;
   int   exp_cnt    = 0;

   always @(negedge clk) begin
      if (frame_abort) abort_seen++;
      if (m_valid && m_ready) out_seen++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic send_bit(input logic b, input logic sof);
      bit done = 1'b0;
      s_valid = 1'b1;
      s_bit   = b;
      s_sof   = sof;
      for (int w = 0; w < 100 && !done; w++) begin
         @(negedge clk);
         if (s_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (!done) check("s_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_word(input logic [14:0] w);
      for (int i = 14; i >= 0; i--) send_bit(w[i], i == 14);
   endtask

   task automatic bump_cnt();
      if (exp_cnt < 255) exp_cnt++;
   endtask

   initial begin
      // S1/S3 from alpha^i = 1,2,4,8,3,6,12,11,5,10,7,14,15,13,9 (i=0..14)
      vecs[0] = '{15'h01D1, 4'd0,  4'd0,  1'b0};  // codeword for message 1
      vecs[1] = '{15'h0001, 4'd1,  4'd1,  1'b1};  // bit 0 set
      vecs[2] = '{15'h4000, 4'd9,  4'd15, 1'b1};  // bit 14 set
      vecs[3] = '{15'h01D0, 4'd1,  4'd1,  1'b1};  // codeword with bit 0 flipped
      vecs[4] = '{15'h0003, 4'd3,  4'd9,  1'b1};  // bits 0,1
      vecs[5] = '{15'h7FFF, 4'd0,  4'd0,  1'b0};  // all ones is a codeword
      vecs[6] = '{15'h0100, 4'd5,  4'd10, 1'b1};  // bit 8 set

      rst = 1'b1; s_valid = 1'b0; s_bit = 1'b0; s_sof = 1'b0; m_ready = 1'b1; cnt_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_word", m_word, 0);
      check("rst_m_s1", m_s1, 0);
      check("rst_m_s3", m_s3, 0);
      check("rst_m_err", m_err, 0);
      check("rst_abort", frame_abort, 0);
      check("rst_err_count", err_count, 0);
      check("rst_s_ready", s_ready, 1);

      for (int v = 0; v < 7; v++) begin
         send_word(vecs[v].word);
         check($sformatf("v%0d_m_valid", v), m_valid, 1);
         check($sformatf("v%0d_m_word", v), m_word, vecs[v].word);
         check($sformatf("v%0d_m_s1", v), m_s1, vecs[v].s1);
         check($sformatf("v%0d_m_s3", v), m_s3, vecs[v].s3);
         check($sformatf("v%0d_m_err", v), m_err, vecs[v].err);
         if (vecs[v].err) bump_cnt();
         check($sformatf("v%0d_err_count", v), err_count, exp_cnt);
         @(posedge clk); #1;
         check($sformatf("v%0d_m_valid_clear", v), m_valid, 0);
      end

      // Backpressure: frame 2's last bit stalls until frame 1 is taken
      m_ready = 1'b0;
      send_word(15'h01D1);
      check("bp_a_valid", m_valid, 1);
      for (int i = 14; i >= 1; i--) send_bit(1'b0 + ((15'h4000 >> i) & 1), i == 14);
      s_valid = 1'b1; s_bit = 1'b0; s_sof = 1'b0;
      @(negedge clk);
      check("bp_s_ready_low", s_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_s_ready_still_low", s_ready, 0);
      check("bp_a_word_stable", m_word, 15'h01D1);
      check("bp_a_valid_held", m_valid, 1);
      m_ready = 1'b1;
      #1 check("bp_s_ready_comb", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("bp_b_valid", m_valid, 1);
      check("bp_b_word", m_word, 15'h4000);
      check("bp_b_s1", m_s1, 9);
      check("bp_b_s3", m_s3, 15);
      bump_cnt();
      check("bp_err_count", err_count, exp_cnt);
      @(posedge clk); #1;
      check("bp_b_consumed", m_valid, 0);

      // Abort: sof after 6 bits restarts the frame
      abort_seen = 0; out_seen = 0;
      for (int i = 0; i < 6; i++) send_bit(1'b1, i == 0);
      check("ab_no_pulse_yet", abort_seen, 0);
      send_bit(1'b0, 1'b1);
      check("ab_pulse", frame_abort, 1);
      for (int i = 13; i >= 0; i--) send_bit(((15'h01D1 >> i) & 1) != 0, 1'b0);
      check("ab_m_valid", m_valid, 1);
      check("ab_m_word", m_word, 15'h01D1);
      check("ab_m_err", m_err, 0);
      repeat (3) @(posedge clk); #1;
      check("ab_pulse_count", abort_seen, 1);
      check("ab_out_count", out_seen, 1);

      // Bits without sof in IDLE are dropped, then reset mid-frame
      abort_seen = 0;
      for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
      check("idle_drop_valid", m_valid, 0);
      for (int i = 0; i < 9; i++) send_bit(1'b1, i == 0);
      check("idle_drop_no_abort", abort_seen, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_cnt = 0;
      repeat (3) @(posedge clk); #1;
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_word", m_word, 0);
      check("mid_rst_s1", m_s1, 0);
      check("mid_rst_s3", m_s3, 0);
      check("mid_rst_err", m_err, 0);
      check("mid_rst_count", err_count, 0);
      check("mid_rst_abort_total", abort_seen, 0);
      send_word(15'h4000);
      check("post_rst_word", m_word, 15'h4000);
      check("post_rst_s1", m_s1, 9);
      bump_cnt();
      check("post_rst_count", err_count, exp_cnt);

      // Saturation over 2^8+2 errored frames
      for (int f = 0; f < 258; f++) begin
         send_word(15'h0001);
         bump_cnt();
         if (f == 253) check("sat_at_255", err_count, exp_cnt);
      end
      check("sat_hold", err_count, 8'hFF);

      // cnt_clr beats a simultaneous errored load
      for (int i = 14; i >= 1; i--) send_bit(1'b0, i == 14);
      cnt_clr = 1'b1;
      send_bit(1'b1, 1'b0);
      cnt_clr = 1'b0;
      exp_cnt = 0;
      check("clr_m_err", m_err, 1);
      check("clr_count", err_count, exp_cnt);
      send_word(15'h0001);
      bump_cnt();
      check("clr_then_inc", err_count, exp_cnt);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bch_serial_rx.md
Name: bch_serial_rx

Overview:
- Upstream front end of the BCH(15,7,2) decode path. Deserialises a bit-serial received codeword, MSB (polynomial degree 14) first.
- Computes syndromes S1 and S3 on the fly by Horner evaluation over GF(16), primitive polynomial x^4+x+1 (alpha^4 = 4'd3).
- Presents the assembled 15-bit word, its syndromes and an error flag on a one-entry valid/ready output register that feeds the combinational error locator / Chien search.
- Word bit layout matches the decoder: bits 14:8 are the message, bits 7:0 are the parity.

Parameters:
- ERR_CNT_W, 8, width of the saturating count of frames with non-zero syndrome.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  serial bit valid.
- s_bit  in  1  received bit value.
- s_sof  in  1  start of frame; qualifies the first (degree-14) bit of a codeword.
- s_ready  out  1  serial bit accepted when s_valid && s_ready.
- m_valid  out  1  output frame valid.
- m_ready  in  1  downstream accepts the frame.
- m_word  out  15  received polynomial; bit i is the coefficient of x^i.
- m_s1  out  4  S1 = sum of r_i*alpha^i.
- m_s3  out  4  S3 = sum of r_i*alpha^(3i).
- m_err  out  1  (m_s1 != 0) || (m_s3 != 0).
- frame_abort  out  1  one-cycle pulse when a partial frame is discarded.
- err_count  out  ERR_CNT_W  saturating count of errored frames.
- cnt_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, bit_cnt=0, shift/syndrome accumulators=0, m_valid=0, m_word=0, m_s1=0, m_s3=0, m_err=0, frame_abort=0, err_count=0. Reset mid-frame discards the frame with no abort pulse. Reset also discards any held output frame.
- Accept event: acc = s_valid && s_ready.
- States:
  - IDLE: acc with s_sof=1 starts a frame and goes to RECV; acc with s_sof=0 drops the bit silently.
  - RECV: counts bits; bit_cnt runs 0..14.
- Frame start and each accepted bit:
  - At frame start: shift = {14'b0, s_bit}, acc1 = s_bit, acc3 = s_bit, bit_cnt = 1.
  - Each later bit: shift = {shift[13:0], s_bit}; acc1 = acc1*alpha ^ s_bit; acc3 = acc3*alpha^3 ^ s_bit.
  - Multiply by alpha: {a[2:0],1'b0} ^ (a[3] ? 4'd3 : 4'd0). alpha^3 is this operation applied three times, all combinational.
- 15th bit accepted (bit_cnt==14):
  - At the same edge, load m_word, m_s1, m_s3 and m_err from the updated values, set m_valid=1, clear the accumulators and return to IDLE.
  - m_valid is visible the cycle after the 15th bit is accepted (latency 1).
- s_sof=1 accepted while in RECV (any bit_cnt, including 14):
  - The partial frame is discarded; frame_abort pulses high the next cycle.
  - The bit starts a new frame (bit_cnt=1).
  - No output is produced.
- s_ready = (bit_cnt != 14) || !m_valid || m_ready.
  - This is a combinational path from m_ready to s_ready.
  - Backpressure stalls only the 15th bit position, including a stalled sof bit at that position.
- Output register:
  - m_valid clears on m_ready && m_valid unless a new frame loads at the same edge; a new load wins and m_valid stays 1.
  - The payload is stable while m_valid && !m_ready.
- err_count:
  - +1 at each load with m_err=1; saturates at all-ones.
  - cnt_clr has priority over a simultaneous increment (result 0).
- s_bit and s_sof are ignored whenever acc=0.

Test Plan:
- Message 7'b0000001, serialised word 15'h01D1 (sof on first bit), m_ready=1 -> m_valid one cycle after the 15th bit; m_word=15'h01D1, m_s1=0, m_s3=0, m_err=0, err_count=0.
- All-zero word with bit 0 flipped (15'h0001) -> m_s1=4'd1, m_s3=4'd1, m_err=1, err_count=1. Bit 14 flipped (15'h4000) -> m_s1=4'd9, m_s3=4'd15, err_count=2.
- Two frames back to back with m_ready=0 -> s_ready low at the 15th bit of frame 2. Raise m_ready -> frame 1 is consumed, and frame 2's last bit is accepted in the same cycle; no data loss.
- s_sof reasserted after 6 bits, then 15 bits of 15'h01D1 -> frame_abort pulses once; the only output is 15'h01D1 with m_err=0.
- Bits with s_sof=0 while in IDLE, then rst asserted mid-frame after 9 bits -> no m_valid; all outputs stay at reset values.
- Force 2^ERR_CNT_W+2 errored frames -> err_count holds 8'hFF. cnt_clr on the same cycle as an errored load -> err_count=0.
